sram_like_arbiter: RTL
======================

Name: sram_like_arbiter

Overview:
- Shares one sram-like slave port (towards the AXI bridge) between two sram-like masters: instruction fetch (inst_*) and data access (data_*).
- Forwards the winning request combinationally and tracks each accepted transaction in an in-order owner FIFO.
- Routes each data_ok/rdata back to the master that issued the transaction.
- Sits between the IF/MEM sram-like front-ends and the sram-to-AXI bridge.

Parameters:
- MAX_OUTST, 2, maximum number of accepted transactions awaiting data_ok (1..4).
- CNT_W, 2, width of the outstanding counter; must hold MAX_OUTST.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- inst_req, inst_wr  in  1 each  fetch request; write flag (tied 0 by IF, still forwarded).
- inst_size  in  2  transfer size.
- inst_addr, inst_wdata  in  32 each  fetch address; write data.
- inst_rdata  out  32  read data for fetch.
- inst_addr_ok, inst_data_ok  out  1 each  fetch handshakes.
- data_req, data_wr  in  1 each  data request; write flag.
- data_size  in  2  transfer size.
- data_addr, data_wdata  in  32 each  data address; write data.
- data_rdata  out  32  read data for data master.
- data_addr_ok, data_data_ok  out  1 each  data handshakes.
- sram_req, sram_wr  out  1 each  slave request; write flag.
- sram_size  out  2  slave transfer size.
- sram_addr, sram_wdata  out  32 each  slave address; write data.
- sram_rdata  in  32  slave read data.
- sram_addr_ok, sram_data_ok  in  1 each  slave handshakes.
- busy  out  1  high while the outstanding count is nonzero.
- err_unexp  out  1  one-cycle pulse on sram_data_ok while the FIFO is empty.

Behaviour:
- Reset (rst=0, async):
  - Owner FIFO empty, count=0, lock=0, last_owner=INST.
  - busy=0, err_unexp=0.
  - All handshake outputs 0 while no request is present.
- Grant selection, combinational:
  - If lock=1, grant = locked owner.
  - Else if exactly one req is high, grant = that master.
  - Else (both high), data wins (fixed priority).
- Full condition: full = (count==MAX_OUTST). When full, sram_req=0 and both addr_ok=0.
- Forwarding when not full and a grant exists:
  - sram_req=1; sram_wr, sram_size, sram_addr, sram_wdata come from the granted master.
  - Granted master's addr_ok = sram_addr_ok; the other master's addr_ok = 0.
- Lock register:
  - Set when sram_req=1 and sram_addr_ok=0; holds the owner.
  - Cleared on the cycle sram_addr_ok=1.
  - Guarantees sram_addr does not switch during a pending address handshake.
  - A higher-priority request arriving while lock=1 waits.
- Accept: on sram_req & sram_addr_ok, push the owner bit (0=INST, 1=DATA) into the FIFO and increment count.
- Return:
  - On sram_data_ok with FIFO non-empty, pop the head.
  - Head owner's data_ok = 1 and its rdata = sram_rdata, same cycle (zero latency).
  - The other master's data_ok = 0.
  - Both rdata outputs are driven with sram_rdata at all times; only data_ok qualifies them.
- Simultaneous accept and return: push and pop in the same cycle; count unchanged.
  - If full, push is not allowed even if a pop occurs in the same cycle; the accept is deferred one cycle.
- Unexpected data: sram_data_ok with FIFO empty produces err_unexp=1 for one cycle. The beat is dropped, no data_ok is issued, and count stays 0.
- Reset mid-transaction: FIFO, count and lock are cleared immediately. Data beats returning after reset are treated as unexpected.
- Ordering: the slave returns data strictly in accept order; the arbiter does no reordering.

Optional Feature:
- ARB_RR_EN defined: on a tie with lock=0, grant goes to the master that is not last_owner. last_owner updates on each accept.
- ARB_RR_EN undefined: fixed data-over-inst priority; last_owner register omitted.

Decomposition:
- Shared package: OWNER_INST=1'b0, OWNER_DATA=1'b1, SIZE_WORD=2'b10.
- Sub-module: owner_fifo (depth MAX_OUTST, width 1).
  - Signals: push, pop, din, dout, empty, full, count.
  - Synchronous push/pop; async active-low clear.

Test Plan:
- Single fetch: inst_req=1, inst_addr=0xBFC00000, addr_ok in cycle 1, data_ok with rdata=0x3C080001 two cycles later -> inst_addr_ok=1 in cycle 1, inst_data_ok=1 and inst_rdata=0x3C080001 in that return cycle, data_data_ok=0, busy 1 -> 0.
- Tie: inst_req and data_req both high, data_addr=0x80001000 -> sram_addr=0x80001000 first. With ARB_RR_EN, a second tie grants inst.
- Lock hold: inst granted with sram_addr_ok=0 for 3 cycles, data_req rises in cycle 1 -> sram_addr stays the inst address until addr_ok; data granted the next cycle.
- Full: MAX_OUTST=2, two accepts (data then inst) with no data_ok -> sram_req=0, busy=1. The first data_ok goes to data_data_ok, the second to inst_data_ok.
- Push+pop: accept and data_ok in the same cycle with count=1 -> count remains 1 and the head owner receives data_ok.
- Error/reset: rst low with 2 outstanding, then release, then sram_data_ok=1 -> err_unexp=1 for one cycle, no master data_ok, busy=0.

Source files
------------

// File: rtl/sram_like_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_like_arbiter_pkg
// Shared definitions for the sram-like two-master arbiter:
//   - owner encoding stored in the in-order owner FIFO (INST / DATA)
//   - word transfer-size encoding
//   - packed command bundle used to mux a master's request onto the slave
//   - small helper returning the opposite owner
// ---------------------------------------------------------------------------
package sram_like_arbiter_pkg;

    typedef logic owner_t;

    localparam owner_t     OWNER_INST = 1'b0;
    localparam owner_t     OWNER_DATA = 1'b1;
    localparam logic [1:0] SIZE_WORD  = 2'b10;

    // One master's request fields, forwarded as a unit to the slave port.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_cmd_t;

    function automatic owner_t other_owner(input owner_t owner);
        return (owner == OWNER_INST) ? OWNER_DATA : OWNER_INST;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// ---------------------------------------------------------------------------
// sram_like_arbiter_owner_fifo
// In-order FIFO of 1-bit owner tags, one entry per accepted transaction that
// is still waiting for its data beat.
// Ports:
//   clk_i     clock
//   rst_ni    asynchronous active-low clear
//   push_i    write din_i (ignored when full)
//   pop_i     drop the head entry (ignored when empty)
//   din_i     owner tag to store
//   dout_o    owner tag at the head
//   empty_o   no entries
//   full_o    DEPTH entries stored
//   count_o   number of stored entries
// ---------------------------------------------------------------------------
import sram_like_arbiter_pkg::*;

module sram_like_arbiter_owner_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  owner_t           din_i,
    output owner_t           dout_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DEPTH-1:0] mem_q,    mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? {PTR_W{1'b0}} : ptr + {{(PTR_W-1){1'b0}}, 1'b1};
    endfunction

    assign empty_o   = (cnt_q == {CNT_W{1'b0}});
    assign full_o    = (cnt_q == DEPTH_C);
    assign count_o   = cnt_q;
    assign dout_o    = mem_q[rd_ptr_q];
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= {DEPTH{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// ---------------------------------------------------------------------------
// sram_like_arbiter
// Shares one sram-like slave port between the instruction-fetch master
// (inst_*) and the data master (data_*). The winning request is forwarded
// combinationally; each accepted transaction's owner is queued in order so
// that data_ok/rdata are routed back to the issuing master with zero latency.
//
// Ports:
//   clk, rst (async, active low)
//   inst_req/wr/size/addr/wdata  -> fetch request;  inst_rdata/addr_ok/data_ok <-
//   data_req/wr/size/addr/wdata  -> data request;   data_rdata/addr_ok/data_ok <-
//   sram_req/wr/size/addr/wdata  <- slave request;  sram_rdata/addr_ok/data_ok ->
//   busy       transactions outstanding
//   err_unexp  data beat arrived with nothing outstanding (beat dropped)
//
// Configuration macro:
//   ARB_RR_EN  when defined, a tie (no lock) goes to the master that did not
//              win the most recent accept; otherwise data always wins ties.
// ---------------------------------------------------------------------------
import sram_like_arbiter_pkg::*;

module sram_like_arbiter #(
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        sram_req,
    output logic        sram_wr,
    output logic [1:0]  sram_size,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    output logic        busy,
    output logic        err_unexp
);

    sram_cmd_t        inst_cmd_s;
    sram_cmd_t        data_cmd_s;
    sram_cmd_t        gnt_cmd_s;
    owner_t           gnt_owner_s;
    logic             gnt_valid_s;
    logic             lock_q,       lock_d;
    owner_t           lock_owner_q, lock_owner_d;
    logic             accept_s;
    logic             pop_s;
    owner_t           head_s;
    logic             empty_s;
    logic             full_s;
    logic [CNT_W-1:0] count_s;
`ifdef ARB_RR_EN
    owner_t           last_owner_q, last_owner_d;
`endif

    assign inst_cmd_s = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
    assign data_cmd_s = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

    // Grant selection: a pending address handshake keeps its owner so the
    // slave never sees the address change before addr_ok.
    always_comb begin
        gnt_owner_s = OWNER_INST;
        gnt_valid_s = 1'b0;
        if (lock_q) begin
            gnt_owner_s = lock_owner_q;
            gnt_valid_s = 1'b1;
        end else if (inst_req && data_req) begin
            gnt_valid_s = 1'b1;
`ifdef ARB_RR_EN
            gnt_owner_s = other_owner(last_owner_q);
`else
            gnt_owner_s = OWNER_DATA;
`endif
        end else if (data_req) begin
            gnt_owner_s = OWNER_DATA;
            gnt_valid_s = 1'b1;
        end else if (inst_req) begin
            gnt_owner_s = OWNER_INST;
            gnt_valid_s = 1'b1;
        end else begin
            gnt_owner_s = OWNER_INST;
            gnt_valid_s = 1'b0;
        end
    end

    assign gnt_cmd_s  = (gnt_owner_s == OWNER_DATA) ? data_cmd_s : inst_cmd_s;

    // No new request while every owner slot is in use, even if a beat is
    // returning this cycle; the accept simply slips by one cycle.
    assign sram_req   = gnt_valid_s & ~full_s;
    assign sram_wr    = gnt_cmd_s.wr;
    assign sram_size  = gnt_cmd_s.size;
    assign sram_addr  = gnt_cmd_s.addr;
    assign sram_wdata = gnt_cmd_s.wdata;

    assign accept_s     = sram_req & sram_addr_ok;
    assign inst_addr_ok = accept_s & (gnt_owner_s == OWNER_INST);
    assign data_addr_ok = accept_s & (gnt_owner_s == OWNER_DATA);

    assign pop_s        = sram_data_ok & ~empty_s;
    assign inst_data_ok = pop_s & (head_s == OWNER_INST);
    assign data_data_ok = pop_s & (head_s == OWNER_DATA);
    assign inst_rdata   = sram_rdata;
    assign data_rdata   = sram_rdata;

    assign err_unexp    = sram_data_ok & empty_s;
    assign busy         = (count_s != {CNT_W{1'b0}});

    // Lock follows an unanswered request and drops on the addr_ok cycle.
    always_comb begin
        lock_d       = sram_req & ~sram_addr_ok;
        lock_owner_d = lock_d ? gnt_owner_s : lock_owner_q;
    end

    // Lock state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_INST;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
        end
    end

`ifdef ARB_RR_EN
    // Remember the most recently accepted owner for tie breaking.
    always_comb begin
        last_owner_d = accept_s ? gnt_owner_s : last_owner_q;
    end

    // Last-owner register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= OWNER_INST;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`endif

    sram_like_arbiter_owner_fifo #(
        .DEPTH (MAX_OUTST),
        .CNT_W (CNT_W)
    ) u_owner_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (accept_s),
        .pop_i   (pop_s),
        .din_i   (gnt_owner_s),
        .dout_o  (head_s),
        .empty_o (empty_s),
        .full_o  (full_s),
        .count_o (count_s)
    );

endmodule
